// File: rtl/fp16_sqrt_sequencer.sv
// FP16 square-root controller: accepts one half-precision operand, runs an
// 11-step restoring sqrt on the normalized mantissa and returns the packed root.
module fp16_sqrt_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [15:0] in_data,
    output logic        in_ready,
    output logic        out_valid,
    output logic [15:0] out_data,
    input  logic        out_ready,
    output logic        busy,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_ITER = 3'd2,
        S_PACK = 3'd3,
        S_DONE = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        R_FINITE = 2'd0,
        R_ZERO   = 2'd1,
        R_INF    = 2'd2,
        R_NAN    = 2'd3
    } res_t;

    state_t             r_state;
    state_t             w_next;
    logic [15:0]        r_operand;
    logic [33:0]        r_rad;
    logic [20:0]        r_rem;
    logic [10:0]        r_root;
    logic [3:0]         r_iter_left;
    logic signed [6:0]  r_half_exp;
    res_t               r_res;
    logic [15:0]        r_out_data;

    // Operand decode, evaluated while the FSM sits in PREP.
    logic               w_sign;
    logic [4:0]         w_exp_field;
    logic [9:0]         w_frac;
    logic [3:0]         w_msb;
    logic [3:0]         w_clz;
    logic [10:0]        w_mant;
    logic signed [6:0]  w_exp;
    logic signed [6:0]  w_exp_even;
    logic signed [6:0]  w_half;
    logic [11:0]        w_mant_prep;
    res_t               w_res;

    assign w_sign      = r_operand[15];
    assign w_exp_field = r_operand[14:10];
    assign w_frac      = r_operand[9:0];

    // NOTE: every combinational output gets a default before any branch so no latch is inferred.
    always_comb begin
        w_msb = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (w_frac[i]) w_msb = 4'(i);
        end
    end

    assign w_clz = 4'd9 - w_msb;

    always_comb begin
        if (w_exp_field == 5'd0) begin
            w_mant = {1'b0, w_frac} << (4'd10 - w_msb);
            w_exp  = -7'sd15 - $signed({3'b000, w_clz});
        end else begin
            w_mant = {1'b1, w_frac};
            w_exp  = $signed({2'b00, w_exp_field}) - 7'sd15;
        end
    end

    assign w_mant_prep = w_exp[0] ? {w_mant, 1'b0} : {1'b0, w_mant};
    assign w_exp_even  = w_exp[0] ? (w_exp - 7'sd1) : w_exp;
    assign w_half      = w_exp_even >>> 1;

    always_comb begin
        if (w_exp_field == 5'd31 && w_frac != 10'd0)      w_res = R_NAN;
        else if (w_exp_field == 5'd0 && w_frac == 10'd0)  w_res = R_ZERO;
        else if (w_sign)                                  w_res = R_NAN;
        else if (w_exp_field == 5'd31)                    w_res = R_INF;
        else                                              w_res = R_FINITE;
    end

    // One restoring-sqrt step.
    logic [12:0] w_trial;
    logic [22:0] w_shift_rem;
    logic        w_ge;
    logic [20:0] w_new_rem;

    assign w_trial     = {r_root[10:0], 2'b01};
    assign w_shift_rem = {r_rem[20:0], r_rad[33:32]};
    assign w_ge        = (w_shift_rem >= {10'b0, w_trial});
    assign w_new_rem   = w_ge ? 21'(w_shift_rem - {10'b0, w_trial}) : w_shift_rem[20:0];

    logic [15:0] w_result;
    always_comb begin
        case (r_res)
            R_FINITE: w_result = {1'b0, 5'(r_half_exp + 7'sd15), r_root[9:0]};
            R_ZERO:   w_result = {r_operand[15], 15'd0};
            R_INF:    w_result = 16'h7C00;
            default:  w_result = 16'hFE00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next = S_PREP;
            end
            S_PREP:  w_next = (w_res == R_FINITE) ? S_ITER : S_PACK;
            S_ITER:  if (r_iter_left == 4'd1) w_next = S_PACK;
            S_PACK:  w_next = S_DONE;
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_operand   <= 16'd0;
            r_rad       <= 34'd0;
            r_rem       <= 21'd0;
            r_root      <= 11'd0;
            r_iter_left <= 4'd0;
            r_half_exp  <= 7'sd0;
            r_res       <= R_FINITE;
            r_out_data  <= 16'd0;
        end else begin
            case (r_state)
                S_IDLE: if (in_valid) r_operand <= in_data;
                S_PREP: begin
                    r_rad       <= {w_mant_prep, 22'd0};
                    r_rem       <= 21'd0;
                    r_root      <= 11'd0;
                    r_iter_left <= 4'd11;
                    r_half_exp  <= w_half;
                    r_res       <= w_res;
                end
                S_ITER: begin
                    r_rad       <= {r_rad[31:0], 2'b00};
                    r_rem       <= w_new_rem;
                    r_root      <= {r_root[9:0], w_ge};
                    r_iter_left <= r_iter_left - 4'd1;
                end
                S_PACK:  r_out_data <= w_result;
                default: ;
            endcase
        end
    end

    assign out_data  = r_out_data;
    assign busy      = (r_state != S_IDLE);
    assign state_dbg = r_state;

endmodule
